// File: rtl/rv_mult_pkg.sv
// Shared definitions for the RISC-V M-extension iterative multiplier:
// func3 encodings, FSM state enum and legal-configuration constants.
package rv_mult_pkg;

    // RISC-V M func3 encodings handled by the multiplier; 1xx is reserved.
    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011
    } mult_func_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

    localparam int LEGAL_DATA_W_A = 32;
    localparam int LEGAL_DATA_W_B = 64;
    localparam int LEGAL_BPC_A    = 1;
    localparam int LEGAL_BPC_B    = 2;
    localparam int LEGAL_BPC_C    = 4;

    // True when the operand width / bits-per-cycle pair is supported.
    function automatic bit cfg_is_legal(input int data_w, input int bpc);
        bit w_ok;
        bit b_ok;
        w_ok = (data_w == LEGAL_DATA_W_A) || (data_w == LEGAL_DATA_W_B);
        b_ok = (bpc == LEGAL_BPC_A) || (bpc == LEGAL_BPC_B) || (bpc == LEGAL_BPC_C);
        return w_ok && b_ok && ((data_w % bpc) == 0);
    endfunction

endpackage

// File: rtl/ex_mult_unit.sv
// Iterative shift-add multiplier for the RISC-V M extension (MUL, MULH,
// MULHSU, MULHU). Retires BITS_PER_CYCLE multiplier bits per enabled cycle,
// giving a fixed latency of DATA_W/BITS_PER_CYCLE cycles in CALC.
module ex_mult_unit
    import rv_mult_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic              start,
    input  logic              kill,
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [4:0]        rd_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [4:0]        rd_out
);

    localparam int N     = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N);

    if (!cfg_is_legal(DATA_W, BITS_PER_CYCLE)) begin : g_bad_cfg
        $error("ex_mult_unit: unsupported DATA_W/BITS_PER_CYCLE combination");
    end

    mult_state_t           state_q;
    mult_state_t           state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [2*DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]     mag_a_q;
    logic                  neg_q;
    logic [2:0]            func3_q;
    logic [4:0]            rd_pend_q;

    logic                  accept;
    logic                  last_iter;
    logic                  a_signed;
    logic                  b_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_W-1:0]     mag_a;
    logic [DATA_W-1:0]     mag_b;
    logic [2*DATA_W-1:0]   acc_step;
    logic [DATA_W:0]       partial;
    logic [2*DATA_W:0]     widened;
    logic [2*DATA_W-1:0]   product;
    logic [DATA_W-1:0]     selected;

    // A start is taken only outside CALC, with the pipeline enabled and no flush.
    assign accept    = en && start && !kill && (state_q != ST_CALC);
    assign last_iter = (state_q == ST_CALC) && (cnt_q == CNT_W'(N - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; kill overrides everything when enabled.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        busy    = (state_q == ST_CALC);
        done    = (state_q == ST_DONE);
        if (en) begin
            if (kill) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: if (start) state_d = ST_CALC;
                    ST_CALC: if (last_iter) state_d = ST_DONE;
                    ST_DONE: state_d = start ? ST_CALC : ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Operand sign conditioning: signedness from func3, then absolute values.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (func3)
            F3_MUL, F3_MULH: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            F3_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        a_neg = a_signed & op_a[DATA_W-1];
        b_neg = b_signed & op_b[DATA_W-1];
        mag_a = a_neg ? (~op_a + 1'b1) : op_a;
        mag_b = b_neg ? (~op_b + 1'b1) : op_b;
    end

    // One iteration: BITS_PER_CYCLE conditional add-and-shift steps on the
    // {high, low} accumulator, where low initially holds |op_b|.
    always_comb begin
        // NOTE: blocking assignments here chain each step's output into the
        // next step within the same cycle.
        acc_step = acc_q;
        partial  = '0;
        widened  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            partial  = {1'b0, acc_step[2*DATA_W-1:DATA_W]}
                     + (acc_step[0] ? {1'b0, mag_a_q} : {(DATA_W + 1){1'b0}});
            widened  = {partial, acc_step[DATA_W-1:0]};
            acc_step = widened[2*DATA_W:1];
        end
        product = neg_q ? (~acc_step + 1'b1) : acc_step;
    end

    // Result slice chosen by the captured func3; reserved encodings give 0.
    always_comb begin
        selected = '0;
        case (func3_q)
            F3_MUL:                       selected = product[DATA_W-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: selected = product[2*DATA_W-1:DATA_W];
            default:                      selected = '0;
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, publish on entry to DONE.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_a_q   <= '0;
            neg_q     <= 1'b0;
            func3_q   <= '0;
            rd_pend_q <= '0;
            result    <= '0;
            rd_out    <= '0;
        end else if (en) begin
            if (kill) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q     <= '0;
                acc_q     <= {{DATA_W{1'b0}}, mag_b};
                mag_a_q   <= mag_a;
                neg_q     <= a_neg ^ b_neg;
                func3_q   <= func3;
                rd_pend_q <= rd_in;
            end else if (state_q == ST_CALC) begin
                acc_q <= acc_step;
                if (last_iter) begin
                    cnt_q  <= '0;
                    result <= selected;
                    rd_out <= rd_pend_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_mult_unit.sv
// Self-checking bench for ex_mult_unit: three instances (1, 2 and 4 bits per
// cycle, 64-bit operands) checked against a wide-arithmetic reference model.
module tb_ex_mult_unit;

    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   arst_n;
    logic                   en;
    logic                   kill;
    logic [2:0]             func3;
    logic [DW-1:0]          op_a;
    logic [DW-1:0]          op_b;
    logic [4:0]             rd_in;
    logic [2:0]             start_v;
    logic [2:0]             busy_v;
    logic [2:0]             done_v;
    logic [2:0][DW-1:0]     result_v;
    logic [2:0][4:0]        rd_out_v;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] last_res [3];
    logic [4:0]    last_rd  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ex_mult_unit #(
            .DATA_W        (DW),
            .BITS_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clk   (clk),
            .arst_n(arst_n),
            .en    (en),
            .start (start_v[g]),
            .kill  (kill),
            .func3 (func3),
            .op_a  (op_a),
            .op_b  (op_b),
            .rd_in (rd_in),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .result(result_v[g]),
            .rd_out(rd_out_v[g])
        );
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    endtask

    function automatic int iters(input int idx);
        return DW / ((idx == 0) ? 1 : ((idx == 1) ? 2 : 4));
    endfunction

    // Reference: extend operands to a wide signed value per signedness,
    // multiply exactly, and pick the slice.
    function automatic logic [DW-1:0] ref_model(input logic [2:0] f3, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        logic signed [2*DW+1:0] ea;
        logic signed [2*DW+1:0] eb;
        logic signed [2*DW+1:0] p;
        ea = (f3 == 3'b011) ? $signed({66'd0, a}) : $signed({{66{a[DW-1]}}, a});
        eb = (f3 == 3'b010 || f3 == 3'b011) ? $signed({66'd0, b}) : $signed({{66{b[DW-1]}}, b});
        p  = ea * eb;
        case (f3)
            3'b000:                 return p[DW-1:0];
            3'b001, 3'b010, 3'b011: return p[2*DW-1:DW];
            default:                return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return 64'h8000_0000_0000_0000;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Starts one operation at a negedge and checks busy window, single done
    // pulse at T+N+1, result and rd_out. Starts and ends at a negedge.
    task automatic run_op(input int idx, input logic [2:0] f3, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [4:0] rd,
                          input logic [DW-1:0] exp, input string tag);
        int n;
        int done_at;
        int done_cnt;
        int busy_bad;
        n = iters(idx);
        done_at = 0; done_cnt = 0; busy_bad = 0;
        func3 = f3; op_a = a; op_b = b; rd_in = rd; start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        for (int c = 1; c <= n + 3; c++) begin
            if (busy_v[idx] !== (c <= n)) busy_bad++;
            if (done_v[idx] === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
                check({tag, " result"}, result_v[idx], exp);
                check({tag, " rd_out"}, 64'(rd_out_v[idx]), 64'(rd));
            end
            @(negedge clk);
        end
        check({tag, " done_cycle"}, 64'(done_at), 64'(n + 1));
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " busy_window"}, 64'(busy_bad), 64'd0);
        last_res[idx] = exp;
        last_rd[idx]  = rd;
    endtask

    // Spec vectors repeated on each bits-per-cycle instance.
    task automatic directed_set(input int idx);
        run_op(idx, 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9,
               64'hFFFF_FFFF_FFFF_FFEB, $sformatf("mul7x-3[%0d]", idx));
        run_op(idx, 3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd3,
               64'h4000_0000_0000_0000, $sformatf("mulh_min[%0d]", idx));
        run_op(idx, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17,
               64'hFFFF_FFFF_FFFF_FFFF, $sformatf("mulhsu[%0d]", idx));
        run_op(idx, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31,
               64'hFFFF_FFFF_FFFF_FFFE, $sformatf("mulhu[%0d]", idx));
    endtask

    initial begin
        int n;
        int done_cnt;
        int done_at;
        int done_last;
        int done_hits [2];
        logic [DW-1:0] a1, b1, a2, b2;

        arst_n = 1'b0; en = 1'b1; kill = 1'b0; start_v = '0;
        func3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        for (int i = 0; i < 3; i++) begin
            last_res[i] = '0;
            last_rd[i]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset busy[%0d]", i), 64'(busy_v[i]), 64'd0);
            check($sformatf("reset done[%0d]", i), 64'(done_v[i]), 64'd0);
            check($sformatf("reset result[%0d]", i), result_v[i], 64'd0);
            check($sformatf("reset rd_out[%0d]", i), 64'(rd_out_v[i]), 64'd0);
        end
        arst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) directed_set(i);

        // Reserved func3 still completes on time with a zero result.
        run_op(1, 3'b101, 64'd12345, 64'd678, 5'd4, 64'd0, "reserved101");

        // Randomized operations, mostly on the 2-bit instance.
        for (int k = 0; k < 30; k++) begin
            int idx;
            logic [2:0] f3;
            idx = (k < 24) ? 1 : ((k % 2 == 0) ? 0 : 2);
            f3 = 3'($urandom_range(0, 7));
            a1 = pick_operand();
            b1 = pick_operand();
            run_op(idx, f3, a1, b1, 5'($urandom_range(0, 31)), ref_model(f3, a1, b1),
                   $sformatf("rand%0d", k));
        end

        n = iters(1);

        // Kill mid-CALC at T+10: idle at T+11, no done, outputs unchanged.
        func3 = 3'b000; op_a = 64'd1000; op_b = 64'd2000; rd_in = 5'd21; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill busy", 64'(busy_v[1]), 64'd0);
        check("kill done", 64'(done_v[1]), 64'd0);
        done_cnt = 0;
        for (int c = 0; c < n + 5; c++) begin
            if (done_v[1] === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("kill no_done", 64'(done_cnt), 64'd0);
        check("kill result_kept", result_v[1], last_res[1]);
        check("kill rd_kept", 64'(rd_out_v[1]), 64'(last_rd[1]));

        // start and kill together: nothing starts.
        start_v[1] = 1'b1; kill = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0; kill = 1'b0;
        check("startkill busy", 64'(busy_v[1]), 64'd0);
        done_cnt = 0;
        for (int c = 0; c < n + 5; c++) begin
            if (done_v[1] === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("startkill no_done", 64'(done_cnt), 64'd0);

        // en low for 5 cycles during CALC: done moves to T+N+6.
        a1 = 64'hFFFF_FFFF_FFFF_FF00; b1 = 64'd77;
        func3 = 3'b000; op_a = a1; op_b = b1; rd_in = 5'd6; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        done_at = 0; done_cnt = 0;
        for (int c = 1; c <= n + 10; c++) begin
            if (done_v[1] === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
                check("en_calc result", result_v[1], ref_model(3'b000, a1, b1));
            end
            if (c == 5) en = 1'b0;
            if (c == 10) en = 1'b1;
            @(negedge clk);
        end
        check("en_calc done_cycle", 64'(done_at), 64'(n + 6));
        check("en_calc done_pulses", 64'(done_cnt), 64'd1);

        // en low for 3 cycles during DONE: done stays high N+1..N+4.
        func3 = 3'b011; op_a = 64'd5; op_b = 64'd9; rd_in = 5'd2; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        done_cnt = 0; done_at = 0; done_last = 0;
        for (int c = 1; c <= n + 8; c++) begin
            if (done_v[1] === 1'b1) begin
                done_cnt++;
                done_last = c;
                if (done_at == 0) done_at = c;
            end
            if (c == n + 1) en = 1'b0;
            if (c == n + 4) en = 1'b1;
            @(negedge clk);
        end
        check("en_done first", 64'(done_at), 64'(n + 1));
        check("en_done last", 64'(done_last), 64'(n + 4));
        check("en_done cycles", 64'(done_cnt), 64'd4);
        last_res[1] = 64'd0;
        last_rd[1]  = 5'd2;

        // Back-to-back: restart in the DONE cycle; a start during CALC is ignored.
        a1 = 64'd123456789; b1 = 64'hFFFF_FFFF_FFFF_FFF0;
        a2 = 64'h0123_4567_89AB_CDEF; b2 = 64'hFEDC_BA98_7654_3210;
        func3 = 3'b001; op_a = a1; op_b = b1; rd_in = 5'd11; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        done_cnt = 0;
        done_hits[0] = 0; done_hits[1] = 0;
        for (int c = 1; c <= 2 * n + 5; c++) begin
            if (done_v[1] === 1'b1) begin
                if (done_cnt < 2) done_hits[done_cnt] = c;
                if (done_cnt == 0) check("b2b result1", result_v[1], ref_model(3'b001, a1, b1));
                if (done_cnt == 1) begin
                    check("b2b result2", result_v[1], ref_model(3'b000, a2, b2));
                    check("b2b rd2", 64'(rd_out_v[1]), 64'd12);
                end
                done_cnt++;
            end
            start_v[1] = 1'b0;
            if (c == n + 1) begin
                func3 = 3'b000; op_a = a2; op_b = b2; rd_in = 5'd12; start_v[1] = 1'b1;
            end
            if (c == n + 6) begin
                func3 = 3'b011; op_a = 64'd3; op_b = 64'd3; rd_in = 5'd13; start_v[1] = 1'b1;
            end
            @(negedge clk);
        end
        start_v[1] = 1'b0;
        check("b2b done1", 64'(done_hits[0]), 64'(n + 1));
        check("b2b done2", 64'(done_hits[1]), 64'(2 * n + 2));
        check("b2b pulses", 64'(done_cnt), 64'd2);

        // Reset at T+20 mid-CALC: all outputs zero at T+21 and no done afterwards.
        func3 = 3'b000; op_a = 64'd50; op_b = 64'd60; rd_in = 5'd25; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= n + 6; c++) begin
            if (c == 21) begin
                check("rst busy", 64'(busy_v[1]), 64'd0);
                check("rst done", 64'(done_v[1]), 64'd0);
                check("rst result", result_v[1], 64'd0);
                check("rst rd_out", 64'(rd_out_v[1]), 64'd0);
            end
            if (done_v[1] === 1'b1) done_cnt++;
            if (c == 20) arst_n = 1'b0;
            if (c == 21) arst_n = 1'b1;
            @(negedge clk);
        end
        check("rst no_done", 64'(done_cnt), 64'd0);

        // Normal operation resumes after the reset.
        a1 = pick_operand(); b1 = pick_operand();
        run_op(1, 3'b010, a1, b1, 5'd30, ref_model(3'b010, a1, b1), "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
